// File: rtl/usart_pkg.sv
// Shared encodings for the UART receive path: parity selection and receiver FSM states.
package usart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/usart_rx_fifo_if.sv
// Bus-side view of the receive FIFO: head word with its error flags, pop handshake, status.
interface usart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  // valid/ready: valid is high while a word is held at the head; the word is consumed on any
  // clock edge where valid && ready; data_out and both error flags describe that head word.
  logic [DATA_BITS-1:0]        data_out;
  logic                        valid;
  logic                        ready;
  logic                        frame_error;
  logic                        parity_error;
  logic                        overrun;
  logic                        clear_overrun;
  logic [$clog2(FIFO_DEPTH):0] fill_level;

  modport master (
    output data_out, valid, frame_error, parity_error, overrun, fill_level,
    input  ready, clear_overrun
  );

  modport slave (
    input  data_out, valid, frame_error, parity_error, overrun, fill_level,
    output ready, clear_overrun
  );
endinterface

// File: rtl/usart_rx_fifo_buf.sv
// Synchronous FIFO holding received words with their error flags; accepts a write when full
// if a read happens in the same cycle.
module usart_rx_fifo_buf #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign fill    = count;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // Head is forced to zero when empty so the outputs read as cleared after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/usart_rx_fifo.sv
// UART receiver: pin synchroniser, oversample tick divider, frame FSM and shifter feeding a
// buffered FIFO with per-word error flags, sticky overrun and RTS flow control.
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int CLKDIV_WIDTH = 12,
  parameter int FIFO_DEPTH   = 16,
  parameter int RTS_LEVEL    = 12
) (
  input  logic                    comm_clock,
  input  logic                    reset,
  input  logic [CLKDIV_WIDTH-1:0] clocks_per_tick,
  input  logic [1:0]              parity_mode,
  input  logic                    two_stop,
  input  logic                    rx_pin,
  output logic                    rts_pin,
  output rx_state_e               rx_state,
  usart_rx_fifo_if.master         bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DBIT_M1 = BW'(DATA_BITS - 1);
  localparam logic [FW-1:0] RTS_LV  = FW'(RTS_LEVEL);

  logic                    sync1, rx_s, rx_prev;
  logic [CLKDIV_WIDTH-1:0] div_cnt;
  logic                    tick;
  logic [TW-1:0]           tick_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_BITS-1:0]    shift;
  logic                    par_err, frm_err, push_q;
  rx_state_e               state, state_next;
  logic                    fall, sample, done, enter_start, par_en;
  logic [TW-1:0]           limit;
  logic [BW-1:0]           stop_last;
  logic                    buf_full, buf_empty, overflow;
  logic [DATA_BITS+1:0]    head;

  assign rx_state    = state;
  assign fall        = rx_prev && !rx_s;
  assign tick        = (div_cnt == '0);
  assign limit       = (state == START) ? HALF_M1 : FULL_M1;
  assign sample      = tick && (tick_cnt == limit);
  assign par_en      = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
  assign stop_last   = {{(BW-1){1'b0}}, two_stop};
  assign enter_start = (state == IDLE) && (state_next == START);

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:   if (fall) state_next = START;
      START:  if (sample) state_next = rx_s ? IDLE : DATA;
      DATA:   if (sample && bit_cnt == DBIT_M1) state_next = par_en ? PARITY : STOP;
      PARITY: if (sample) state_next = STOP;
      STOP: begin
        if (sample && bit_cnt == stop_last) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      div_cnt  <= CLKDIV_WIDTH'(1);
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      sync1   <= rx_pin;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      push_q  <= done;
      // Reloading on START entry centres the half-bit wait on the detected edge.
      if (enter_start || tick) div_cnt <= clocks_per_tick;
      else                     div_cnt <= div_cnt - 1'b1;
      if (enter_start)  tick_cnt <= '0;
      else if (tick)    tick_cnt <= (tick_cnt == limit) ? '0 : tick_cnt + 1'b1;
      if (state_next != state) bit_cnt <= '0;
      else if (sample)         bit_cnt <= bit_cnt + 1'b1;
      if (enter_start) begin
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end
      if (state == DATA && sample)   shift   <= {rx_s, shift[DATA_BITS-1:1]};
      if (state == PARITY && sample) par_err <= (^shift) ^ rx_s ^ (parity_mode == PAR_ODD);
      if (state == STOP && sample && !rx_s) frm_err <= 1'b1;
    end
  end

  usart_rx_fifo_buf #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (comm_clock),
    .rst_n   (reset),
    .wr_en   (push_q),
    .wr_data ({par_err, frm_err, shift}),
    .rd_en   (bus.ready),
    .rd_data (head),
    .full    (buf_full),
    .empty   (buf_empty),
    .fill    (bus.fill_level)
  );

  assign bus.valid        = !buf_empty;
  assign bus.data_out     = head[DATA_BITS-1:0];
  assign bus.frame_error  = head[DATA_BITS];
  assign bus.parity_error = head[DATA_BITS+1];
  // A full FIFO only drops the word when no pop frees a slot in the same cycle.
  assign overflow         = push_q && buf_full && !bus.ready;

  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      bus.overrun <= 1'b0;
      rts_pin     <= 1'b0;
    end else begin
      if (overflow)               bus.overrun <= 1'b1;
      else if (bus.clear_overrun) bus.overrun <= 1'b0;
      rts_pin <= (bus.fill_level >= RTS_LV);
    end
  end
endmodule

// File: tb/tb_usart_rx_fifo.sv
// Directed bench for usart_rx_fifo: serial frames in, scoreboard-checked words out.
module tb_usart_rx_fifo;
  import usart_pkg::*;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int CW = 12;
  localparam int FD = 16;
  localparam int RL = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] clocks_per_tick = '0;
  logic [1:0]    parity_mode = 2'b00;
  logic          two_stop = 1'b0;
  logic          rx_pin = 1'b1;
  logic          rts_pin;
  rx_state_e     rx_state;

  usart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();

  usart_rx_fifo #(
    .DATA_BITS(DB), .OVERSAMPLE(OS), .CLKDIV_WIDTH(CW), .FIFO_DEPTH(FD), .RTS_LEVEL(RL)
  ) dut (
    .comm_clock      (clk),
    .reset           (rst_n),
    .clocks_per_tick (clocks_per_tick),
    .parity_mode     (parity_mode),
    .two_stop        (two_stop),
    .rx_pin          (rx_pin),
    .rts_pin         (rts_pin),
    .rx_state        (rx_state),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [DB+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pop is compared against the oldest expected {parity_err, frame_err, data}.
  initial begin
    logic [DB+1:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (bus.valid && bus.ready) begin
        got = {bus.parity_error, bus.frame_error, bus.data_out};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", got, $time);
        end else begin
          check("pop_word", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic use_par, input logic par_bit,
                            input logic stop1, input logic use_stop2, input logic stop2);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop1);
    if (use_stop2) drive_bit(stop2);
    rx_pin = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!bus.valid && k < max) begin
      @(negedge clk);
      k++;
    end
    check("valid_timeout", 32'(bus.valid), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_data"}, 32'(bus.data_out), 32'd0);
    check({tag, "_ferr"}, 32'(bus.frame_error), 32'd0);
    check({tag, "_perr"}, 32'(bus.parity_error), 32'd0);
    check({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
    check({tag, "_fill"}, 32'(bus.fill_level), 32'd0);
    check({tag, "_rts"}, 32'(rts_pin), 32'd0);
    check({tag, "_state"}, 32'(rx_state), 32'(IDLE));
  endtask

  initial begin
    int k;
    bus.ready = 1'b0;
    bus.clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0x75, then a single-cycle pop.
    exp_q.push_back({2'b00, 8'h75});
    send_frame(8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_valid(64);
    check("head_0x75", 32'(bus.data_out), 32'h75);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    check("valid_after_pop", 32'(bus.valid), 32'd0);
    bus.ready = 1'b1;

    // Even parity on 0x0F: parity bit 1 is wrong, 0 is right.
    parity_mode = 2'b01;
    exp_q.push_back({2'b10, 8'h0F});
    send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 8'h0F});
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // Odd parity on 0x01: parity bit 0 is right.
    parity_mode = 2'b10;
    exp_q.push_back({2'b00, 8'h01});
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    parity_mode = 2'b00;

    // Low stop bit, then a clean word.
    exp_q.push_back({2'b01, 8'hFF});
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (16) @(negedge clk);
    exp_q.push_back({2'b00, 8'h41});
    send_frame(8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Two stop bits with the second one low.
    two_stop = 1'b1;
    exp_q.push_back({2'b01, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (16) @(negedge clk);
    two_stop = 1'b0;

    // Short low glitch on an idle line.
    rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    rx_pin = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_valid", 32'(bus.valid), 32'd0);
    check("glitch_state", 32'(rx_state), 32'(IDLE));
    check("glitch_fill", 32'(bus.fill_level), 32'd0);

    // Fill the FIFO with no consumer: RTS at 12, overrun on the 17th.
    bus.ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) exp_q.push_back({2'b00, 8'(8'h20 + i)});
      send_frame(8'(8'h20 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (i == 11) check("rts_at_11", 32'(rts_pin), 32'd0);
      if (i == 12) check("rts_at_12", 32'(rts_pin), 32'd1);
      if (i == 16) check("ovr_at_16", 32'(bus.overrun), 32'd0);
    end
    check("fill_full", 32'(bus.fill_level), 32'd16);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    check("head_after_ovr", 32'(bus.data_out), 32'h21);
    bus.clear_overrun = 1'b1;
    @(negedge clk);
    bus.clear_overrun = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(bus.overrun), 32'd0);
    bus.ready = 1'b1;
    k = 0;
    while (bus.fill_level != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("drain_fill", 32'(bus.fill_level), 32'd0);
    repeat (3) @(negedge clk);
    check("rts_after_drain", 32'(rts_pin), 32'd0);

    // Reset in the middle of a data bit with one word already buffered.
    bus.ready = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("pre_reset_fill", 32'(bus.fill_level), 32'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (8) @(negedge clk);
    check("mid_frame_state", 32'(rx_state), 32'(DATA));
    rst_n = 1'b0;
    rx_pin = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.ready = 1'b1;
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
